bist_response_analyzer: RTL and testbench
=========================================

Name: bist_response_analyzer

Overview:
Downstream stage of the scan-chain BIST path, and also its sequencer. It drives scan_en to the 8-bit scan chain around the 4x4 multiplier, alternating shift and capture windows for a fixed number of patterns. Every bit unloaded on scan_out is compacted into a serial-input MISR. At the end of the run the signature is compared against a golden value, and pass/fail is reported with done.

Parameters:
CHAIN_LEN, 8, scan chain length; bits shifted per shift window (>=1)
NUM_PATTERNS, 16, number of capture cycles per run (>=0)
SIG_WIDTH, 16, MISR width
MISR_POLY, 16'h1021, feedback taps; x^SIG_WIDTH term implicit
GOLDEN_SIG, 16'h0000, expected final signature (used when the optional feature is off)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to begin a run; honoured only in IDLE or DONE
scan_out  input  1  serial response from the scan chain
scan_en  output  1  1 = shift, 0 = capture/idle; drives the scan chain
busy  output  1  1 while in SHIFT or CAPTURE
done  output  1  1 while in DONE
pass  output  1  valid when done=1: 1 if sig_out==golden, else 0; forced to 0 when done=0
sig_out  output  SIG_WIDTH  current MISR contents

Behaviour:
- Interface (decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a posedge), from any state including mid-run:
  - state=IDLE, MISR=0, counters=0.
  - scan_en=0, busy=0, done=0, pass=0, sig_out=0.
- Registers:
  - bit_cnt, width clog2(CHAIN_LEN)+1.
  - pat_cnt, width clog2(NUM_PATTERNS+1)+1.
- FSM states: IDLE, SHIFT, CAPTURE, DONE. scan_en=1 only in SHIFT (Moore output).
- IDLE:
  - start=1 -> SHIFT.
  - On that edge: MISR<=0, bit_cnt<=0, pat_cnt<=0.
- SHIFT:
  - Each posedge samples scan_out into the MISR and increments bit_cnt.
  - On the edge that samples the CHAIN_LEN-th bit:
    - if pat_cnt==NUM_PATTERNS -> DONE;
    - else -> CAPTURE, with bit_cnt<=0.
- CAPTURE:
  - Lasts exactly one cycle with scan_en=0, so the chain loads the product.
  - pat_cnt<=pat_cnt+1, next state SHIFT.
  - The MISR does not update in CAPTURE.
- DONE:
  - Holds MISR, done=1 and pass until reset.
  - start=1 in DONE restarts the run exactly as from IDLE.
- start while busy=1 is ignored; no queuing.
- MISR update, applied only on SHIFT edges:
  - fb = sig[SIG_WIDTH-1]
  - nxt = (sig<<1) ^ (fb ? MISR_POLY : 0)
  - nxt[0] ^= scan_out
  - All arithmetic mod 2^SIG_WIDTH.
- Run length:
  - Shift windows = NUM_PATTERNS+1. The first window unloads the chain's reset content (zeros); the last window flushes the final capture.
  - Busy cycles = (NUM_PATTERNS+1)*CHAIN_LEN + NUM_PATTERNS.
  - Defaults: 17*8 + 16 = 152 busy cycles.
  - If start is seen at edge k, busy=1 and scan_en=1 from cycle k+1, and done rises after cycle k+152.
- NUM_PATTERNS=0: one shift window only (pure unload), then DONE; no CAPTURE cycle.
- pass is derived from the registered MISR and golden value while in DONE, so it is stable for the whole of DONE.

Optional Feature:
Macro BIST_GOLDEN_IN_EN.
- Defined:
  - Adds input port golden_sig [SIG_WIDTH-1:0].
  - It is registered on the start-accept edge and used for the pass comparison; later changes during the run are ignored.
  - Reset clears the registered copy to 0.
- Undefined:
  - No extra port; the comparison uses the GOLDEN_SIG parameter.
  - All other behaviour is identical.

Test Plan:
1. Defaults, scan_out held at 0, GOLDEN_SIG=0; pulse start -> busy high for 152 cycles; scan_en low exactly on 16 isolated cycles (after shift bits 8,16,...,128); done=1, sig_out=16'h0000, pass=1.
2. CHAIN_LEN=8, NUM_PATTERNS=0, scan_out held at 1, GOLDEN_SIG=16'h00FF -> 8 busy cycles, no CAPTURE; sig_out=16'h00FF, pass=1; repeat with GOLDEN_SIG=16'h00FE -> pass=0.
3. Defaults, start pulsed again at cycle 50 of a run -> ignored; done still rises after 152 busy cycles from the first start.
4. rst=1 at cycle 40 of a run -> next cycle state IDLE, scan_en=0, busy=0, done=0, sig_out=0; a new start then completes a full 152-cycle run.
5. Full integration with the LFSR pattern generator and the scan-chain multiplier, all reset together, start on the first post-reset cycle -> sig_out equals a bit-accurate reference model; done held and start in DONE reruns to the identical signature.
6. BIST_GOLDEN_IN_EN defined: golden_sig=16'h00FF at start then changed to 16'h1234 mid-run, setup as in test 2 -> pass=1.

Source files
------------

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - scan BIST sequencer with serial-input MISR and golden compare (optional BIST_GOLDEN_IN_EN)
module bist_response_analyzer #(
  parameter int                   CHAIN_LEN    = 8,
  parameter int                   NUM_PATTERNS = 16,
  parameter int                   SIG_WIDTH    = 16,
  parameter logic [SIG_WIDTH-1:0] MISR_POLY    = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 scan_out,
`ifdef BIST_GOLDEN_IN_EN
  input  logic [SIG_WIDTH-1:0] golden_sig,
`endif
  output logic                 scan_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] sig_out
);

  localparam int BW = $clog2(CHAIN_LEN) + 1;
  localparam int PW = $clog2(NUM_PATTERNS + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [PW-1:0]        pat_cnt;
  logic [SIG_WIDTH-1:0] misr;
  logic [SIG_WIDTH-1:0] misr_nxt;
  logic [SIG_WIDTH-1:0] golden;
  logic                 accept;
  logic                 last_bit;
  logic                 last_pat;

  assign last_bit = (bit_cnt == BW'(CHAIN_LEN - 1));
  assign last_pat = (pat_cnt == PW'(NUM_PATTERNS));

  // Galois-style MISR step: shift, fold the dropped MSB back through the taps, inject scan_out at bit 0
  always_comb begin
    misr_nxt    = (misr << 1) ^ (misr[SIG_WIDTH-1] ? MISR_POLY : '0);
    misr_nxt[0] = misr_nxt[0] ^ scan_out;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; start is only accepted from IDLE or DONE
  always_comb begin
    state_nxt = state;
    scan_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scan_en = 1'b1;
        busy    = 1'b1;
        if (last_bit) begin
          state_nxt = last_pat ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy      = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: MISR compaction on shift edges, bit/pattern counters, run restart clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      misr    <= '0;
      bit_cnt <= '0;
      pat_cnt <= '0;
    end else if (accept) begin
      misr    <= '0;
      bit_cnt <= '0;
      pat_cnt <= '0;
    end else begin
      case (state)
        S_SHIFT: begin
          misr    <= misr_nxt;
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
        S_CAPTURE: begin
          pat_cnt <= pat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BIST_GOLDEN_IN_EN
  logic [SIG_WIDTH-1:0] golden_q;

  // Golden value is latched when a run is accepted so later input changes cannot affect the verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      golden_q <= '0;
    end else if (accept) begin
      golden_q <= golden_sig;
    end
  end

  assign golden = golden_q;
`else
  assign golden = GOLDEN_SIG;
`endif

  assign pass    = done && (misr == golden);
  assign sig_out = misr;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - directed self-checking bench for bist_response_analyzer
module tb_bist_response_analyzer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, so_a, so_b;
  logic        scan_en_a, busy_a, done_a, pass_a;
  logic        scan_en_b, busy_b, done_b, pass_b;
  logic        scan_en_c, busy_c, done_c, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;
`ifdef BIST_GOLDEN_IN_EN
  logic [15:0] gold_a, gold_b, gold_c;
`endif

  bist_response_analyzer u_a (
    .clk(clk), .rst(rst), .start(start_a), .scan_out(so_a),
`ifdef BIST_GOLDEN_IN_EN
    .golden_sig(gold_a),
`endif
    .scan_en(scan_en_a), .busy(busy_a), .done(done_a), .pass(pass_a), .sig_out(sig_a)
  );

  bist_response_analyzer #(.NUM_PATTERNS(0), .GOLDEN_SIG(16'h00FF)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .scan_out(so_b),
`ifdef BIST_GOLDEN_IN_EN
    .golden_sig(gold_b),
`endif
    .scan_en(scan_en_b), .busy(busy_b), .done(done_b), .pass(pass_b), .sig_out(sig_b)
  );

  bist_response_analyzer #(.NUM_PATTERNS(0), .GOLDEN_SIG(16'h00FE)) u_c (
    .clk(clk), .rst(rst), .start(start_b), .scan_out(so_b),
`ifdef BIST_GOLDEN_IN_EN
    .golden_sig(gold_c),
`endif
    .scan_en(scan_en_c), .busy(busy_c), .done(done_c), .pass(pass_c), .sig_out(sig_c)
  );

  typedef struct {
    logic [7:0]  pat;
    logic [15:0] sig;
    logic        pb;
    logic        pc;
  } vec_t;

  vec_t       tbl [4];
  logic       data [152];
  int         total = 0;
  int         bad = 0;
  int         nbusy, ncap, nbad, nb;
  logic [15:0] exp_sig, first_sig;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_sig();
    logic [15:0] s;
    logic        fb;
    s = '0;
    for (int i = 0; i < 152; i++) begin
      if (i % 9 != 8) begin
        fb = s[15];
        s  = {s[14:0], 1'b0};
        if (fb) s = s ^ 16'h1021;
        s[0] = s[0] ^ data[i];
      end
    end
    return s;
  endfunction

  // Drives one full run on u_a; optionally re-pulses start at busy cycle 'again'
  task automatic run_a(input int again, output int nbz, output int ncp, output int nbd);
    nbz = 0; ncp = 0; nbd = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    while (busy_a && nbz < 400) begin
      if (!scan_en_a) begin
        ncp++;
        if (nbz % 9 != 8) nbd++;
      end else if (nbz % 9 == 8) begin
        nbd++;
      end
      so_a    = (nbz < 152) ? data[nbz] : 1'b0;
      start_a = (nbz == again);
      tick();
      start_a = 1'b0;
      nbz++;
    end
  endtask

  initial begin
    tbl[0] = '{pat: 8'hFF, sig: 16'h00FF, pb: 1'b1, pc: 1'b0};
    tbl[1] = '{pat: 8'hFE, sig: 16'h00FE, pb: 1'b0, pc: 1'b1};
    tbl[2] = '{pat: 8'hA5, sig: 16'h00A5, pb: 1'b0, pc: 1'b0};
    tbl[3] = '{pat: 8'h00, sig: 16'h0000, pb: 1'b0, pc: 1'b0};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; so_a = 1'b0; so_b = 1'b0;
`ifdef BIST_GOLDEN_IN_EN
    gold_a = 16'h0000; gold_b = 16'h00FF; gold_c = 16'h00FE;
`endif
    tick(); tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_scan_en", scan_en_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_sig", sig_a, 0);
    rst = 1'b0;
    tick();
    chk("idle_done", done_a, 0);

    // Single-window runs, all restarted from DONE after the first
    for (int v = 0; v < 4; v++) begin
`ifdef BIST_GOLDEN_IN_EN
      gold_b = 16'h00FF; gold_c = 16'h00FE;
`endif
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_busy_start", busy_b, 1);
      chk("b_scan_en_start", scan_en_b, 1);
      nb = 0;
      for (int i = 7; i >= 0; i--) begin
        so_b = tbl[v].pat[i];
`ifdef BIST_GOLDEN_IN_EN
        if (i == 3) begin gold_b = 16'h1234; gold_c = 16'h1234; end
`endif
        if (busy_b) nb++;
        tick();
      end
      chk("b_busy_cycles", nb, 8);
      chk("b_done", done_b, 1);
      chk("b_busy_end", busy_b, 0);
      chk("b_sig", sig_b, tbl[v].sig);
      chk("b_pass", pass_b, tbl[v].pb);
      chk("c_pass", pass_c, tbl[v].pc);
    end

    // Full default run with an all-zero response
    for (int i = 0; i < 152; i++) data[i] = 1'b0;
    run_a(-1, nbusy, ncap, nbad);
    chk("a0_busy_cycles", nbusy, 152);
    chk("a0_captures", ncap, 16);
    chk("a0_capture_pos", nbad, 0);
    chk("a0_done", done_a, 1);
    chk("a0_sig", sig_a, 16'h0000);
    chk("a0_pass", pass_a, 1);

    // Start during a run must be ignored
    run_a(50, nbusy, ncap, nbad);
    chk("a1_busy_cycles", nbusy, 152);
    chk("a1_done", done_a, 1);

    // Random response against reference MISR, then rerun from DONE
    for (int i = 0; i < 152; i++) data[i] = 1'($urandom_range(1, 0));
    data[0] = 1'b1;
    exp_sig = model_sig();
    run_a(-1, nbusy, ncap, nbad);
    chk("a2_busy_cycles", nbusy, 152);
    chk("a2_sig", sig_a, exp_sig);
    chk("a2_pass", pass_a, (exp_sig == 16'h0000));
    first_sig = sig_a;
    tick(); tick(); tick();
    chk("a2_done_held", done_a, 1);
    chk("a2_sig_held", sig_a, exp_sig);
    run_a(-1, nbusy, ncap, nbad);
    chk("a3_rerun_sig", sig_a, first_sig);
    chk("a3_rerun_busy", nbusy, 152);

    // Reset in the middle of a run
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      so_a = data[i];
      tick();
    end
    chk("a4_mid_busy", busy_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("a4_rst_busy", busy_a, 0);
    chk("a4_rst_scan_en", scan_en_a, 0);
    chk("a4_rst_done", done_a, 0);
    chk("a4_rst_sig", sig_a, 0);
    chk("a4_rst_pass", pass_a, 0);
    run_a(-1, nbusy, ncap, nbad);
    chk("a4_busy_cycles", nbusy, 152);
    chk("a4_sig", sig_a, exp_sig);
    chk("a4_done", done_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
